mem_bist_initiator: RTL and testbench

- Initiator for the single-port memory valid/ready request interface.
- On start, writes a deterministic pattern to a contiguous address range, then reads the range back and compares each word.
- Reports pass/fail, error count and first failing address.
- Sits in front of the memory model as the front-door counterpart to back-door image loading, and is used for self-check and fill.

---
 rtl/mem_bist_initiator_pkg.sv | 37 +++
 rtl/mem_addr_seq.sv | 62 ++++++
 rtl/mem_bist_initiator.sv | 195 +++++++++++++++++++
 tb/tb_mem_bist_initiator.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bist_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_initiator_pkg
// Description : Shared definitions for the memory BIST initiator: controller
//               state encoding, request opcodes and the fill/check pattern.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bist_initiator_pkg;

    // Controller state encoding
    localparam int c_state_w = 3;
    typedef logic [c_state_w-1:0] bist_state_t;

    localparam bist_state_t c_st_idle  = 3'd0;
    localparam bist_state_t c_st_wr    = 3'd1;
    localparam bist_state_t c_st_rd    = 3'd2;
    localparam bist_state_t c_st_rwait = 3'd3;
    localparam bist_state_t c_st_fin   = 3'd4;

    // Request opcode carried on wr_rd_o
    localparam logic c_op_wr = 1'b1;
    localparam logic c_op_rd = 1'b0;

    // The pattern is computed on a wide vector so that one function serves
    // every WIDTH; callers cast the result down to their word width.
    localparam int c_pat_max_w = 64;

    // data(a) = seed XOR zero-extended address
    function automatic logic [c_pat_max_w-1:0] bist_pattern(
        input logic [c_pat_max_w-1:0] seed,
        input logic [c_pat_max_w-1:0] addr
    );
        return seed ^ addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_addr_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_seq
// Description : Loadable modulo-DEPTH address counter with a remaining-count
//               down-counter. o_last flags the final location of the range.
//   clk, rst      : clock, asynchronous active-high reset
//   i_load        : capture i_start_addr / i_num_loc and begin a new pass
//   i_reload      : restart the pass from the captured start and count
//   i_advance     : step to the next address (wraps DEPTH-1 -> 0)
//   o_addr        : current address
//   o_last        : current address is the last location of the pass
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_seq #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH:0]   i_num_loc,
    input  logic                  i_reload,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam logic [ADDR_WIDTH-1:0] c_addr_max = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_one      = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_start;
    logic [ADDR_WIDTH:0]   r_num;
    logic [ADDR_WIDTH:0]   r_remain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_start  <= '0;
            r_num    <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_addr   <= i_start_addr;
            r_start  <= i_start_addr;
            r_num    <= i_num_loc;
            r_remain <= i_num_loc;
        end else if (i_reload) begin
            r_addr   <= r_start;
            r_remain <= r_num;
        end else if (i_advance) begin
            // Explicit wrap so non-power-of-two depths stay in range
            r_addr   <= (r_addr == c_addr_max) ? '0 : r_addr + 1'b1;
            r_remain <= r_remain - c_one;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remain == c_one);

endmodule
`default_nettype wire

// File: rtl/mem_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module      : mem_bist_initiator
// Description : Front-door BIST initiator for a single-port valid/ready
//               memory. Writes seed^addr over a contiguous (wrapping) range,
//               reads it back one word at a time and reports the result.
//   clk, rst                : clock, asynchronous active-high reset
//   start_i, start_addr_i,
//   num_loc_i, seed_i       : run request and its parameters
//   busy_o, done_o, pass_o,
//   err_count_o,
//   first_err_addr_o        : run status and result
//   addr_o, wr_rd_o,
//   wr_data_o, valid_o,
//   ready_i, rd_data_i      : memory request interface
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_initiator
    import mem_bist_initiator_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   num_loc_i,
    input  logic [WIDTH-1:0]      seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wr_rd_o,
    output logic [WIDTH-1:0]      wr_data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic [WIDTH-1:0]      rd_data_i
);

    localparam int                  c_lat_w     = 2;
    localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] c_depth_cnt = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_err_max   = '1;
    localparam logic [ADDR_WIDTH:0] c_one       = (ADDR_WIDTH + 1)'(1);

    bist_state_t           r_state;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_valid;
    logic                  r_wr_rd;
    logic [WIDTH-1:0]      r_seed;
    logic [ADDR_WIDTH:0]   r_err_count;
    logic [ADDR_WIDTH-1:0] r_first_err;
    logic [c_lat_w-1:0]    r_lat_cnt;

    logic [ADDR_WIDTH-1:0] w_seq_addr;
    logic                  w_seq_last;
    logic                  w_accept;
    logic                  w_xfer;
    logic                  w_lat_done;
    logic                  w_reload;
    logic                  w_advance;
    logic [ADDR_WIDTH:0]   w_num_clamped;
    logic [WIDTH-1:0]      w_pattern;
    logic                  w_mismatch;
    logic [ADDR_WIDTH:0]   w_err_next;

    assign w_num_clamped = (num_loc_i > c_depth_cnt) ? c_depth_cnt : num_loc_i;
    assign w_accept      = (r_state == c_st_idle) && start_i;
    assign w_xfer        = r_valid && ready_i;
    // Last wait cycle: rd_data_i is valid RD_LATENCY edges after the read handshake
    assign w_lat_done    = (r_state == c_st_rwait) && (r_lat_cnt == c_lat_last);
    // End of write pass: restart the range for the read pass
    assign w_reload      = (r_state == c_st_wr) && w_xfer && w_seq_last;
    assign w_advance     = ((r_state == c_st_wr) && w_xfer && !w_seq_last) ||
                           (w_lat_done && !w_seq_last);

    assign w_pattern  = WIDTH'(bist_pattern(c_pat_max_w'(r_seed), c_pat_max_w'(w_seq_addr)));
    assign w_mismatch = (rd_data_i != w_pattern);
    assign w_err_next = (w_mismatch && (r_err_count != c_err_max)) ? r_err_count + c_one
                                                                   : r_err_count;

    mem_addr_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_seq (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_accept),
        .i_start_addr (start_addr_i),
        .i_num_loc    (w_num_clamped),
        .i_reload     (w_reload),
        .i_advance    (w_advance),
        .o_addr       (w_seq_addr),
        .o_last       (w_seq_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_valid     <= 1'b0;
            r_wr_rd     <= 1'b0;
            r_seed      <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_lat_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_seed      <= seed_i;
                        r_err_count <= '0;
                        r_first_err <= '0;
                        if (w_num_clamped == '0) begin
                            // Empty run: report straight away
                            r_state <= c_st_fin;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= c_st_wr;
                            r_busy  <= 1'b1;
                            r_pass  <= 1'b0;
                            r_valid <= 1'b1;
                            r_wr_rd <= c_op_wr;
                        end
                    end
                end
                c_st_wr: begin
                    if (w_xfer && w_seq_last) begin
                        r_state <= c_st_rd;
                        r_wr_rd <= c_op_rd;
                    end
                end
                c_st_rd: begin
                    if (w_xfer) begin
                        r_state   <= c_st_rwait;
                        r_valid   <= 1'b0;
                        r_lat_cnt <= '0;
                    end
                end
                c_st_rwait: begin
                    if (w_lat_done) begin
                        r_err_count <= w_err_next;
                        if (w_mismatch && (r_err_count == '0)) begin
                            r_first_err <= w_seq_addr;
                        end
                        if (w_seq_last) begin
                            r_state <= c_st_fin;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_state <= c_st_rd;
                            r_valid <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                c_st_fin: begin
                    // start_i is deliberately not looked at here
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o           = r_busy;
    assign done_o           = r_done;
    assign pass_o           = r_pass;
    assign err_count_o      = r_err_count;
    assign first_err_addr_o = r_first_err;
    assign valid_o          = r_valid;
    assign wr_rd_o          = r_wr_rd;
    assign addr_o           = w_seq_addr;
    assign wr_data_o        = w_pattern;

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bist_initiator
// Description : Self-checking bench for mem_bist_initiator. A memory model
//               with RD_LATENCY read delay answers requests; a transaction
//               list derived from the run parameters predicts every request,
//               the read-gap timing, done/busy and the final result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bist_initiator;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int RD_LAT = 2;
    localparam int ERRMAX = (1 << (AW + 1)) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_i = 1'b0;
    logic [AW-1:0]    start_addr_i = '0;
    logic [AW:0]      num_loc_i = '0;
    logic [WIDTH-1:0] seed_i = '0;
    logic             busy_o, done_o, pass_o, wr_rd_o, valid_o;
    logic [AW:0]      err_count_o;
    logic [AW-1:0]    first_err_addr_o, addr_o;
    logic [WIDTH-1:0] wr_data_o;
    logic             ready_i = 1'b1;
    logic [WIDTH-1:0] rd_data_i = '0;

    always #5 clk = ~clk;

    mem_bist_initiator #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .start_addr_i(start_addr_i),
        .num_loc_i(num_loc_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .err_count_o(err_count_o), .first_err_addr_o(first_err_addr_o),
        .addr_o(addr_o), .wr_rd_o(wr_rd_o), .wr_data_o(wr_data_o), .valid_o(valid_o),
        .ready_i(ready_i), .rd_data_i(rd_data_i)
    );

    typedef struct { bit wr; int addr; logic [WIDTH-1:0] data; } txn_t;

    txn_t             q[$];
    logic [WIDTH-1:0] mem [DEPTH];
    int               total = 0;
    int               bad   = 0;

    // model state
    bit               run_active = 0;
    bit               zero_pending = 0;
    bit               done_seen = 0;
    int               gap = 0;
    int               exp_err = 0;
    int               exp_first = 0;
    bit               exp_pass = 0;
    bit               corrupt_pending = 0;
    bit               rand_ready = 0;
    bit               rd_pend = 0;
    int               rd_cnt = 0;
    int               rd_addr = 0;
    bit               prev_hold = 0;
    logic [AW-1:0]    prev_addr;
    logic             prev_wr_rd;
    logic [WIDTH-1:0] prev_data;
    int               cyc_in_run = 0;
    logic [WIDTH-1:0] first_wr_data;
    int               wr_log[$];
    int               rd_log[$];
    int               wr_hits[DEPTH];
    int               rd_hits[DEPTH];

    function automatic logic [WIDTH-1:0] pat(input logic [WIDTH-1:0] s, input int a);
        return s ^ WIDTH'(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // One clock: check at negedge, then update the memory model after posedge
    task automatic cycle();
        bit   exp_done, exp_valid, xfer, accept;
        txn_t t;
        int   n;
        @(negedge clk);
        exp_done = 0;
        if (zero_pending) begin
            exp_done     = 1;
            zero_pending = 0;
        end
        if (gap > 0) begin
            if (gap <= RD_LAT) gap++;
            else begin
                gap = 0;
                if (q.size() == 0) exp_done = 1;
            end
        end
        if (exp_done) begin
            run_active = 0;
            exp_pass   = (exp_err == 0);
        end
        done_seen = exp_done;
        exp_valid = run_active && (gap == 0) && (q.size() > 0);
        chk("valid", valid_o, exp_valid);
        chk("done", done_o, exp_done);
        chk("busy", busy_o, run_active);
        if (!run_active) begin
            chk("pass", pass_o, exp_pass);
            chk("err_count", err_count_o, exp_err);
            chk("first_err", first_err_addr_o, exp_first);
        end
        if (exp_valid) begin
            t = q[0];
            chk("addr", addr_o, t.addr);
            chk("wr_rd", wr_rd_o, t.wr);
            if (t.wr) chk("wr_data", wr_data_o, t.data);
        end
        if (prev_hold && valid_o) begin
            chk("hold_addr", addr_o, prev_addr);
            chk("hold_wr_rd", wr_rd_o, prev_wr_rd);
            chk("hold_data", wr_data_o, prev_data);
        end
        prev_hold  = valid_o && !ready_i;
        prev_addr  = addr_o;
        prev_wr_rd = wr_rd_o;
        prev_data  = wr_data_o;

        xfer   = exp_valid && ready_i;
        accept = start_i && !run_active && !exp_done;
        if (xfer) begin
            t = q.pop_front();
            if (t.wr) begin
                if (wr_log.size() == 0) first_wr_data = wr_data_o;
                mem[addr_o] = wr_data_o;
                wr_log.push_back(t.addr);
                wr_hits[t.addr]++;
            end else begin
                if (corrupt_pending) begin
                    mem[20] = mem[20] ^ 16'h0101;
                    mem[25] = mem[25] ^ 16'h8000;
                    corrupt_pending = 0;
                end
                rd_addr = int'(addr_o);
                rd_pend = 1;
                rd_cnt  = RD_LAT - 1;
                rd_log.push_back(t.addr);
                rd_hits[t.addr]++;
                if (mem[t.addr] !== t.data) begin
                    if (exp_err == 0) exp_first = t.addr;
                    if (exp_err < ERRMAX) exp_err++;
                end
                gap = 1;
            end
        end
        if (accept) begin
            n = int'(num_loc_i);
            if (n > DEPTH) n = DEPTH;
            q.delete();
            for (int k = 0; k < n; k++)
                q.push_back('{1'b1, (int'(start_addr_i) + k) % DEPTH,
                              pat(seed_i, (int'(start_addr_i) + k) % DEPTH)});
            for (int k = 0; k < n; k++)
                q.push_back('{1'b0, (int'(start_addr_i) + k) % DEPTH,
                              pat(seed_i, (int'(start_addr_i) + k) % DEPTH)});
            exp_err = 0; exp_first = 0; exp_pass = 0;
            run_active   = (n != 0);
            zero_pending = (n == 0);
        end
        @(posedge clk);
        #1;
        if (rd_pend && rd_cnt == 0) begin
            rd_data_i = mem[rd_addr];
            rd_pend   = 0;
        end else begin
            if (rd_pend) rd_cnt--;
            rd_data_i = WIDTH'($urandom);
        end
        ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        cyc_in_run++;
    endtask

    task automatic do_reset_mid_run();
        rst = 1'b1;
        #2;
        chk("rst_ctrl", {valid_o, wr_rd_o, busy_o, done_o, pass_o}, 0);
        chk("rst_addr_data", {addr_o, wr_data_o}, 0);
        chk("rst_result", {err_count_o, first_err_addr_o}, 0);
        q.delete();
        run_active = 0; zero_pending = 0; gap = 0; rd_pend = 0; prev_hold = 0;
        exp_err = 0; exp_first = 0; exp_pass = 0; corrupt_pending = 0;
        @(negedge clk);
        chk("rst_no_done", done_o, 0);
        rst = 1'b0;
    endtask

    task automatic run(input int sa, input int n, input logic [WIDTH-1:0] seed,
                       input bit rr, input bit corrupt, input int rst_at,
                       input bit start_mid, input bit start_at_done, output int cycles);
        int guard = 0;
        wr_log.delete(); rd_log.delete();
        foreach (wr_hits[i]) begin wr_hits[i] = 0; rd_hits[i] = 0; end
        rand_ready = rr; corrupt_pending = corrupt; done_seen = 0; cyc_in_run = 0;
        start_addr_i = AW'(sa); num_loc_i = (AW + 1)'(n); seed_i = seed; start_i = 1'b1;
        cycle();
        start_i = 1'b0;
        // scramble: the DUT must only use what it latched
        start_addr_i = AW'($urandom); num_loc_i = (AW + 1)'($urandom); seed_i = WIDTH'($urandom);
        while (!done_seen && guard < 4000) begin
            if (start_mid && guard == 3) start_i = 1'b1;
            if (start_at_done && q.size() == 0 && (gap == RD_LAT + 1 || zero_pending)) begin
                start_i = 1'b1; num_loc_i = (AW + 1)'(5);
            end
            cycle();
            start_i = 1'b0;
            guard++;
            if (rst_at > 0 && wr_log.size() == rst_at) begin
                do_reset_mid_run();
                cycles = cyc_in_run;
                return;
            end
        end
        chk("run_done", done_seen, 1);
        cycles = cyc_in_run;
        rand_ready = 0;
        repeat (3) cycle();
    endtask

    int cyc;
    int mism;
    int exp_wrap[8] = '{60, 61, 62, 63, 0, 1, 2, 3};
    logic [WIDTH-1:0] wseed;

    initial begin
        foreach (mem[i]) mem[i] = '0;
        rst = 1'b1;
        #12;
        chk("reset_outputs", {valid_o, wr_rd_o, busy_o, done_o, pass_o, err_count_o,
                              first_err_addr_o, addr_o, wr_data_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) cycle();

        // basic run
        run(16, 16, 16'hA5A0, 0, 0, 0, 0, 0, cyc);
        chk("basic_cycles", cyc, 66);
        chk("basic_first_wdata", first_wr_data, 16'hA5B0);
        chk("basic_writes", wr_log.size(), 16);
        chk("basic_reads", rd_log.size(), 16);
        chk("basic_pass", pass_o, 1);
        chk("basic_err", err_count_o, 0);

        // wrap, on a known background
        foreach (mem[i]) mem[i] = 16'h5A00 ^ WIDTH'(i);
        wseed = 16'h3C3C;
        run(60, 8, wseed, 0, 0, 0, 0, 0, cyc);
        chk("wrap_wr_len", wr_log.size(), 8);
        chk("wrap_rd_len", rd_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_wr_addr", wr_log[i], exp_wrap[i]);
            chk("wrap_rd_addr", rd_log[i], exp_wrap[i]);
        end
        mism = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((i >= 60 || i <= 3) ? (mem[i] !== pat(wseed, i))
                                    : (mem[i] !== (16'h5A00 ^ WIDTH'(i)))) mism++;
        end
        chk("wrap_mem_image", mism, 0);

        // backpressure, with an ignored start mid-run
        run(40, 20, 16'h1234, 1, 0, 0, 1, 0, cyc);
        chk("bp_pass", pass_o, 1);

        // fault injection after the write pass
        run(16, 16, 16'hBEEF, 1, 1, 0, 0, 1, cyc);
        chk("fault_err", err_count_o, 2);
        chk("fault_first", first_err_addr_o, 20);
        chk("fault_pass", pass_o, 0);

        // empty run
        run(5, 0, 16'hFFFF, 0, 0, 0, 0, 0, cyc);
        chk("zero_cycles", cyc, 2);
        chk("zero_pass", pass_o, 1);

        // full depth, and clamped oversize
        run(7, 64, 16'h0F0F, 0, 0, 0, 0, 0, cyc);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (wr_hits[i] != 1 || rd_hits[i] != 1) mism++;
        chk("full_once_each", mism, 0);
        run(0, 70, 16'h7777, 1, 0, 0, 0, 0, cyc);
        chk("clamp_writes", wr_log.size(), 64);

        // reset during the write pass, then a normal run
        run(10, 12, 16'h4444, 0, 0, 5, 0, 0, cyc);
        repeat (2) cycle();
        run(3, 10, 16'h9999, 0, 0, 0, 0, 0, cyc);
        chk("post_reset_pass", pass_o, 1);
        chk("post_reset_cycles", cyc, 2 + 10 * (2 + RD_LAT));

        // randomized runs
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(0, 63), $urandom_range(0, 70), WIDTH'($urandom), 1,
                1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), r == 3, cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
